// File: rtl/stack_controller.sv
// Multi-cycle control unit for the 8-bit stack-machine CPU: sequences fetch, decode and execute from the 3-bit opcode.
// Latency: one state per clk; PUSH/POP/JZ 4 cycles, JMP 2, ADD/SUB/AND 6, NOT 5; strobes are registered and held a full cycle.
// Backpressure: none; the datapath samples every strobe at negedge and never stalls the controller.
//
// Ports:
//   clk            system clock, state advances on posedge
//   rst            synchronous active-low reset
//   inst[2:0]      opcode (IR[7:5]) from the datapath
//   ld_IR .. write_enable  single-bit datapath strobes, active-high
//   ALUop[1:0]     00 add, 01 sub, 10 and, 11 not(A)
module stack_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] inst,
   output logic       ld_IR,
   output logic       PCorIR,
   output logic       push,
   output logic       pop,
   output logic       MEMorALU,
   output logic       ldA,
   output logic       ldB,
   output logic       PCup,
   output logic       PCwrite,
   output logic       J,
   output logic       JZ,
   output logic       write_enable,
   output logic [1:0] ALUop
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_PUSH_RD = 4'd2,
      S_PUSH_WR = 4'd3,
      S_POP_LDA = 4'd4,
      S_POP_WR  = 4'd5,
      S_JZ_LDA  = 4'd6,
      S_JZ_EX   = 4'd7,
      S_AL_POPA = 4'd8,
      S_AL_POPB = 4'd9,
      S_AL_EXE  = 4'd10,
      S_AL_PUSH = 4'd11
   } state_t;

   typedef struct packed {
      logic       ld_ir;
      logic       pc_or_ir;
      logic       push;
      logic       pop;
      logic       mem_or_alu;
      logic       ld_a;
      logic       ld_b;
      logic       pc_up;
      logic       pc_write;
      logic       j;
      logic       jz;
      logic       write_enable;
      logic [1:0] alu_op;
   } ctrl_t;

   state_t state_q, state_d;
   ctrl_t  ctrl_q,  ctrl_d;
   // Low for the first cycle out of reset so the FETCH strobes get one full
   // cycle before the FSM starts advancing.
   logic   run_q,   run_d;

   // Strobes for a given state. Only DECODE and AL_EXE look at the opcode.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ld_ir = 1'b1;
            c.pc_up = 1'b1;
         end
         S_DECODE: begin
            c.pc_up    = 1'b1;
            // JZ defers its PC update to JZ_EX, once the stack top is known.
            c.pc_write = (op != 3'b011);
            c.j        = (op == 3'b010);
         end
         S_PUSH_RD: c.pc_or_ir = 1'b1;
         S_PUSH_WR: c.push     = 1'b1;
         S_POP_LDA: begin
            c.ld_a = 1'b1;
            c.pop  = 1'b1;
         end
         S_POP_WR: begin
            c.pc_or_ir     = 1'b1;
            c.write_enable = 1'b1;
         end
         S_JZ_LDA: begin
            // PC has not advanced yet, so PCup here makes ALUres = PC+1 for JZ_EX.
            c.ld_a  = 1'b1;
            c.pop   = 1'b1;
            c.pc_up = 1'b1;
         end
         S_JZ_EX: begin
            c.jz       = 1'b1;
            c.pc_write = 1'b1;
         end
         S_AL_POPA: begin
            c.ld_a = 1'b1;
            c.pop  = 1'b1;
         end
         S_AL_POPB: begin
            c.ld_b = 1'b1;
            c.pop  = 1'b1;
         end
         S_AL_EXE:  c.alu_op = op[1:0];
         S_AL_PUSH: begin
            c.mem_or_alu = 1'b1;
            c.push       = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic state_t next_state(input state_t s, input logic [2:0] op);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH: n = S_DECODE;
         S_DECODE: begin
            case (op)
               3'b000:  n = S_PUSH_RD;
               3'b001:  n = S_POP_LDA;
               3'b010:  n = S_FETCH;
               3'b011:  n = S_JZ_LDA;
               default: n = S_AL_POPA;
            endcase
         end
         S_PUSH_RD: n = S_PUSH_WR;
         S_POP_LDA: n = S_POP_WR;
         S_JZ_LDA:  n = S_JZ_EX;
         // NOT is unary: skip the second pop.
         S_AL_POPA: n = (op == 3'b111) ? S_AL_EXE : S_AL_POPB;
         S_AL_POPB: n = S_AL_EXE;
         S_AL_EXE:  n = S_AL_PUSH;
         default:   n = S_FETCH;
      endcase
      return n;
   endfunction

   // Strobes are registered from the next state. The opcode used for DECODE
   // is loaded at FETCH's negedge, so it is valid at the edge leaving FETCH.
   always_comb begin
      run_d = 1'b1;
      if (run_q) begin
         state_d = next_state(state_q, inst);
      end else begin
         state_d = S_FETCH;
      end
      ctrl_d = decode_ctrl(state_d, inst);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         run_q   <= run_d;
      end
   end

   assign ld_IR        = ctrl_q.ld_ir;
   assign PCorIR       = ctrl_q.pc_or_ir;
   assign push         = ctrl_q.push;
   assign pop          = ctrl_q.pop;
   assign MEMorALU     = ctrl_q.mem_or_alu;
   assign ldA          = ctrl_q.ld_a;
   assign ldB          = ctrl_q.ld_b;
   assign PCup         = ctrl_q.pc_up;
   assign PCwrite      = ctrl_q.pc_write;
   assign J            = ctrl_q.j;
   assign JZ           = ctrl_q.jz;
   assign write_enable = ctrl_q.write_enable;
   assign ALUop        = ctrl_q.alu_op;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: per-cycle strobe vectors expected for each instruction are queued when the opcode is driven.
// Each cycle is sampled 1 time unit after posedge and compared against the head of the queue.
// Covers reset hold, release, all eight opcodes, and reset in the middle of an ADD.
module tb_stack_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] inst;
   logic       ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable;
   logic [1:0] ALUop;
   logic [13:0] obs;

   // Vector layout: {ld_IR,PCorIR,push,pop,MEMorALU,ldA,ldB,PCup,PCwrite,J,JZ,write_enable,ALUop}
   localparam logic [13:0] V_LDIR   = 14'h2000;
   localparam logic [13:0] V_PCORIR = 14'h1000;
   localparam logic [13:0] V_PUSH   = 14'h0800;
   localparam logic [13:0] V_POP    = 14'h0400;
   localparam logic [13:0] V_MEMALU = 14'h0200;
   localparam logic [13:0] V_LDA    = 14'h0100;
   localparam logic [13:0] V_LDB    = 14'h0080;
   localparam logic [13:0] V_PCUP   = 14'h0040;
   localparam logic [13:0] V_PCW    = 14'h0020;
   localparam logic [13:0] V_J      = 14'h0010;
   localparam logic [13:0] V_JZ     = 14'h0008;
   localparam logic [13:0] V_WE     = 14'h0004;
   localparam logic [13:0] V_ZERO   = 14'h0000;

   logic [13:0] exp_q[$];
   int n_chk  = 0;
   int n_pass = 0;

   stack_controller dut (
      .clk          (clk),
      .rst          (rst),
      .inst         (inst),
      .ld_IR        (ld_IR),
      .PCorIR       (PCorIR),
      .push         (push),
      .pop          (pop),
      .MEMorALU     (MEMorALU),
      .ldA          (ldA),
      .ldB          (ldB),
      .PCup         (PCup),
      .PCwrite      (PCwrite),
      .J            (J),
      .JZ           (JZ),
      .write_enable (write_enable),
      .ALUop        (ALUop)
   );

   assign obs = {ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable, ALUop};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, got, want);
   endtask

   // Expected strobe sequence of one instruction, FETCH first.
   task automatic push_seq(input logic [2:0] op);
      logic [13:0] dec;
      exp_q.push_back(V_LDIR | V_PCUP);
      dec = V_PCUP;
      if (op != 3'b011) dec = dec | V_PCW;
      if (op == 3'b010) dec = dec | V_J;
      exp_q.push_back(dec);
      case (op)
         3'b000: begin
            exp_q.push_back(V_PCORIR);
            exp_q.push_back(V_PUSH);
         end
         3'b001: begin
            exp_q.push_back(V_LDA | V_POP);
            exp_q.push_back(V_PCORIR | V_WE);
         end
         3'b010: ;
         3'b011: begin
            exp_q.push_back(V_LDA | V_POP | V_PCUP);
            exp_q.push_back(V_JZ | V_PCW);
         end
         default: begin
            exp_q.push_back(V_LDA | V_POP);
            if (op != 3'b111) exp_q.push_back(V_LDB | V_POP);
            exp_q.push_back({12'd0, op[1:0]});
            exp_q.push_back(V_PUSH | V_MEMALU);
         end
      endcase
   endtask

   task automatic check_next(input string tag);
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 14'd1, 14'd0);
      else chk(tag, obs, exp_q.pop_front());
   endtask

   // Entered 1 unit after the posedge that starts FETCH; leaves at the same
   // point of the following FETCH, so instruction length is checked too.
   task automatic run_instr(input logic [2:0] op);
      int n;
      inst = op;
      push_seq(op);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         check_next($sformatf("op%0d_cyc%0d", op, i));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst  = 1'b0;
      inst = 3'b101;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("reset_zero", obs, V_ZERO);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_instr(3'b000);
      run_instr(3'b010);
      run_instr(3'b011);
      run_instr(3'b001);
      run_instr(3'b101);
      run_instr(3'b111);
      run_instr(3'b100);
      run_instr(3'b110);

      // Reset asserted while an ADD sits in AL_POPB.
      inst = 3'b100;
      push_seq(3'b100);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         check_next($sformatf("midrst_cyc%0d", i));
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_zero", obs, V_ZERO);
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Restart must begin at FETCH with no stale push from the abandoned ADD.
      run_instr(3'b101);
      exp_q.push_back(V_LDIR | V_PCUP);
      check_next("final_fetch");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
